// File: rtl/dmem_if.sv
// CPU-to-data-memory request/response bundle.
// The CPU drives the master side; dmem_stall_ctrl is the slave.
interface dmem_if;
    logic [15:0] dmemaddr;
    logic [15:0] dmemwdata;
    logic        dmemwrite;
    logic        dmemread;
    logic [15:0] dmemrdata;
    logic        dmemstall;
    logic [15:0] stallcount;

    modport master (
        output dmemaddr, dmemwdata, dmemwrite, dmemread,
        input  dmemrdata, dmemstall, stallcount
    );

    modport slave (
        input  dmemaddr, dmemwdata, dmemwrite, dmemread,
        output dmemrdata, dmemstall, stallcount
    );
endinterface

// File: rtl/dmem_stall_ctrl.sv
// Multi-cycle data memory behind a one-entry posted write buffer
// with read-hit forwarding, pipeline stall output and stall counter.
module dmem_stall_ctrl #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic  clock,
    input  logic  reset,
    dmem_if.slave bus
);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAITWB,
        R_ACCESS
    } rstate_t;

    logic [15:0]          mem [2**ADDR_BITS];
    logic                 wb_valid;
    logic [ADDR_BITS-1:0] wb_addr;
    logic [15:0]          wb_data;
    logic [3:0]           dcnt;
    logic [3:0]           acnt;
    rstate_t              rstate;
    logic [15:0]          rdata_q;
    logic [15:0]          scount;

    logic [ADDR_BITS-1:0] idx;
    logic                 wr_req;
    logic                 rd_req;
    logic                 drain_done;
    logic                 wr_take;
    logic                 hit;
    logic                 rd_hit;
    logic                 stall;
    logic                 unused_addr;

    assign idx         = bus.dmemaddr[ADDR_BITS:1];
    assign unused_addr = ^{bus.dmemaddr[15:ADDR_BITS+1], bus.dmemaddr[0]};

    assign wr_req     = bus.dmemwrite;
    assign rd_req     = bus.dmemread & ~bus.dmemwrite;
    assign drain_done = wb_valid && (dcnt == 4'd0);
    // Final drain cycle frees the slot at the same edge: no bubble.
    assign wr_take    = wr_req && (!wb_valid || drain_done);
    assign hit        = wb_valid && (idx == wb_addr);
    assign rd_hit     = rd_req && (rstate == R_IDLE) && hit;

    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            if (wr_req) begin
                stall = !wr_take;
            end else if (rd_req) begin
                unique case (rstate)
                    R_IDLE:   stall = !hit;
                    R_WAITWB: stall = 1'b1;
                    R_ACCESS: stall = (acnt != 4'd0);
                    default:  stall = 1'b0;
                endcase
            end
        end
    end

    assign bus.dmemstall  = stall;
    assign bus.dmemrdata  = rd_hit ? wb_data : rdata_q;
    assign bus.stallcount = scount;

    always_ff @(posedge clock) begin
        if (!reset && drain_done) begin
            mem[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            dcnt     <= '0;
            acnt     <= '0;
            rstate   <= R_IDLE;
            rdata_q  <= '0;
            scount   <= '0;
        end else begin
            if (wr_take) begin
                wb_valid <= 1'b1;
                wb_addr  <= idx;
                wb_data  <= bus.dmemwdata;
                dcnt     <= LAT_M1;
            end else if (drain_done) begin
                wb_valid <= 1'b0;
            end else if (wb_valid) begin
                dcnt <= dcnt - 4'd1;
            end

            // Data is latched on the edge where the access count reaches
            // zero, so the zero-count cycle returns it without stalling.
            if (rd_req) begin
                unique case (rstate)
                    R_IDLE: begin
                        if (!hit) begin
                            if (wb_valid && !drain_done) begin
                                rstate <= R_WAITWB;
                            end else begin
                                rstate <= R_ACCESS;
                                acnt   <= LAT_M1;
                                if (LAT_M1 == 4'd0) rdata_q <= mem[idx];
                            end
                        end
                    end
                    R_WAITWB: begin
                        if (drain_done || !wb_valid) begin
                            rstate <= R_ACCESS;
                            acnt   <= LAT_M1;
                            if (LAT_M1 == 4'd0) rdata_q <= mem[idx];
                        end
                    end
                    R_ACCESS: begin
                        if (acnt == 4'd0) begin
                            rstate <= R_IDLE;
                        end else begin
                            acnt <= acnt - 4'd1;
                            if (acnt == 4'd1) rdata_q <= mem[idx];
                        end
                    end
                    default: rstate <= R_IDLE;
                endcase
            end

            if (stall && (scount != 16'hFFFF)) begin
                scount <= scount + 16'd1;
            end
        end
    end
endmodule
